simple_dma: RTL and testbench

SIMPLE_DMA -- requirements
Module: simple_dma

---
 rtl/simple_dma_pkg.sv | 26 ++
 rtl/simple_dma_regs.sv | 133 +++++++++++++
 rtl/simple_dma.sv | 183 ++++++++++++++++++
 tb/tb_simple_dma.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_dma_pkg.sv
// Shared constants for the simple word-copy DMA: register offsets, control/status
// bit positions and the copy FSM state encoding.
package simple_dma_pkg;

    localparam logic [4:0] OffSrc    = 5'h00;
    localparam logic [4:0] OffDst    = 5'h04;
    localparam logic [4:0] OffLen    = 5'h08;
    localparam logic [4:0] OffCtrl   = 5'h0C;
    localparam logic [4:0] OffStatus = 5'h10;

    localparam int unsigned CtrlStartBit  = 0;
    localparam int unsigned CtrlIrqEnBit  = 1;

    localparam int unsigned StatusBusyBit = 0;
    localparam int unsigned StatusDoneBit = 1;
    localparam int unsigned StatusErrBit  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdRsp,
        StWrReq,
        StWrRsp
    } dma_state_e;

endpackage

// File: rtl/simple_dma_regs.sv
// Config register file and fixed one-cycle device-port responder for simple_dma.
// Produces the start pulse and holds the done/err flags set by the copy engine.
module simple_dma_regs
    import simple_dma_pkg::*;
#(
    parameter int unsigned LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                dev_req_i,
    input  logic                dev_we_i,
    input  logic [3:0]          dev_be_i,
    input  logic [31:0]         dev_addr_i,
    input  logic [31:0]         dev_wdata_i,
    output logic                dev_rvalid_o,
    output logic [31:0]         dev_rdata_o,
    output logic                dev_err_o,

    input  logic                busy_i,
    input  logic                done_set_i,
    input  logic                err_set_i,
    output logic                start_o,
    output logic [31:0]         src_o,
    output logic [31:0]         dst_o,
    output logic [LenWidth-1:0] len_o,
    output logic                irq_en_o,
    output logic                done_o,
    output logic                err_o
);

    logic [4:0]          offset;
    logic                off_ok;
    logic [31:0]         rd_data;
    logic                wr;
    logic                cfg_wr;

    logic [31:0]         src_q;
    logic [31:0]         dst_q;
    logic [LenWidth-1:0] len_q;
    logic                irq_en_q;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic                derr_q;

    // Byte enables and upper address bits carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{dev_be_i, dev_addr_i[31:5]};

    assign offset = dev_addr_i[4:0];
    assign wr     = dev_req_i & dev_we_i;
    assign cfg_wr = wr & ~busy_i;

    assign start_o = cfg_wr & (offset == OffCtrl) & dev_wdata_i[CtrlStartBit];

    always_comb begin
        rd_data = '0;
        off_ok  = 1'b1;
        case (offset)
            OffSrc:    rd_data = src_q;
            OffDst:    rd_data = dst_q;
            OffLen:    rd_data = 32'(len_q);
            OffCtrl:   rd_data[CtrlIrqEnBit] = irq_en_q;
            OffStatus: begin
                rd_data[StatusBusyBit] = busy_i;
                rd_data[StatusDoneBit] = done_q;
                rd_data[StatusErrBit]  = err_q;
            end
            default:   off_ok = 1'b0;
        endcase
    end

    // A set from the copy engine always beats a clear in the same cycle.
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (start_o) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (wr && (offset == OffStatus)) begin
            if (dev_wdata_i[StatusDoneBit]) done_d = 1'b0;
            if (dev_wdata_i[StatusErrBit])  err_d  = 1'b0;
        end
        if (done_set_i) done_d = 1'b1;
        if (err_set_i)  err_d  = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (cfg_wr && (offset == OffSrc)) src_q <= dev_wdata_i;
            if (cfg_wr && (offset == OffDst)) dst_q <= dev_wdata_i;
            if (cfg_wr && (offset == OffLen)) len_q <= dev_wdata_i[LenWidth-1:0];
            if (wr && (offset == OffCtrl))    irq_en_q <= dev_wdata_i[CtrlIrqEnBit];
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            derr_q   <= 1'b0;
        end else begin
            rvalid_q <= dev_req_i;
            derr_q   <= dev_req_i & ~off_ok;
            rdata_q  <= (dev_req_i && !dev_we_i && off_ok) ? rd_data : '0;
        end
    end

    assign dev_rvalid_o = rvalid_q;
    assign dev_rdata_o  = rdata_q;
    assign dev_err_o    = derr_q;

    assign src_o    = src_q;
    assign dst_o    = dst_q;
    assign len_o    = len_q;
    assign irq_en_o = irq_en_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: rtl/simple_dma.sv
// Single-channel word-copy DMA: reads one word from the source pointer, writes it to
// the destination pointer, repeats LEN times with at most one host transaction in flight.
module simple_dma
    import simple_dma_pkg::*;
#(
    parameter int unsigned LenWidth = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_addr_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,

    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,

    output logic        dma_irq_o
);

    dma_state_e          state_q, state_d;

    logic [31:0]         src_ptr_q;
    logic [31:0]         dst_ptr_q;
    logic [31:0]         data_q;
    logic [LenWidth-1:0] cnt_q;

    logic                start;
    logic [31:0]         cfg_src;
    logic [31:0]         cfg_dst;
    logic [LenWidth-1:0] cfg_len;
    logic                irq_en;
    logic                done;
    logic                err;
    logic                busy;
    logic                done_set;
    logic                err_set;
    logic                last_word;

    assign busy      = (state_q != StIdle);
    assign last_word = (cnt_q == LenWidth'(1));

    simple_dma_regs #(
        .LenWidth (LenWidth)
    ) u_regs (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dev_req_i    (dev_req_i),
        .dev_we_i     (dev_we_i),
        .dev_be_i     (dev_be_i),
        .dev_addr_i   (dev_addr_i),
        .dev_wdata_i  (dev_wdata_i),
        .dev_rvalid_o (dev_rvalid_o),
        .dev_rdata_o  (dev_rdata_o),
        .dev_err_o    (dev_err_o),
        .busy_i       (busy),
        .done_set_i   (done_set),
        .err_set_i    (err_set),
        .start_o      (start),
        .src_o        (cfg_src),
        .dst_o        (cfg_dst),
        .len_o        (cfg_len),
        .irq_en_o     (irq_en),
        .done_o       (done),
        .err_o        (err)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && (cfg_len != '0)) state_d = StRdReq;
            end
            StRdReq: begin
                if (host_gnt_i) state_d = StRdRsp;
            end
            StRdRsp: begin
                if (host_rvalid_i) state_d = host_err_i ? StIdle : StWrReq;
            end
            StWrReq: begin
                if (host_gnt_i) state_d = StWrRsp;
            end
            StWrRsp: begin
                if (host_rvalid_i) state_d = (host_err_i || last_word) ? StIdle : StRdReq;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_be_o    = 4'h0;
        host_addr_o  = '0;
        host_wdata_o = '0;
        done_set     = 1'b0;
        err_set      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && (cfg_len == '0)) done_set = 1'b1;
            end
            StRdReq: begin
                host_req_o  = 1'b1;
                host_be_o   = 4'hF;
                host_addr_o = src_ptr_q;
            end
            StRdRsp: begin
                if (host_rvalid_i && host_err_i) begin
                    done_set = 1'b1;
                    err_set  = 1'b1;
                end
            end
            StWrReq: begin
                host_req_o   = 1'b1;
                host_we_o    = 1'b1;
                host_be_o    = 4'hF;
                host_addr_o  = dst_ptr_q;
                host_wdata_o = data_q;
            end
            StWrRsp: begin
                if (host_rvalid_i) begin
                    done_set = host_err_i | last_word;
                    err_set  = host_err_i;
                end
            end
            default: ;
        endcase
    end

    // Working copies are separate from the programmed values so readback stays stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && (cfg_len != '0)) begin
                        src_ptr_q <= {cfg_src[31:2], 2'b00};
                        dst_ptr_q <= {cfg_dst[31:2], 2'b00};
                        cnt_q     <= cfg_len;
                    end
                end
                StRdRsp: begin
                    if (host_rvalid_i && !host_err_i) data_q <= host_rdata_i;
                end
                StWrRsp: begin
                    if (host_rvalid_i && !host_err_i) begin
                        src_ptr_q <= src_ptr_q + 32'd4;
                        dst_ptr_q <= dst_ptr_q + 32'd4;
                        cnt_q     <= cnt_q - LenWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dma_irq_o = done & irq_en;

endmodule

// File: tb/tb_simple_dma.sv
// Directed bench for simple_dma with a host memory model that supports optional
// random grant/response latency and a one-shot read error.
module tb_simple_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        dev_req = 1'b0;
    logic        dev_we = 1'b0;
    logic [3:0]  dev_be = 4'h0;
    logic [31:0] dev_addr = '0;
    logic [31:0] dev_wdata = '0;
    logic        dev_rvalid;
    logic [31:0] dev_rdata;
    logic        dev_err;

    logic        host_req;
    logic        host_gnt;
    logic [31:0] host_addr;
    logic        host_we;
    logic [3:0]  host_be;
    logic [31:0] host_wdata;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        host_err;
    logic        dma_irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simple_dma dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dev_req_i     (dev_req),
        .dev_we_i      (dev_we),
        .dev_be_i      (dev_be),
        .dev_addr_i    (dev_addr),
        .dev_wdata_i   (dev_wdata),
        .dev_rvalid_o  (dev_rvalid),
        .dev_rdata_o   (dev_rdata),
        .dev_err_o     (dev_err),
        .host_req_o    (host_req),
        .host_gnt_i    (host_gnt),
        .host_addr_o   (host_addr),
        .host_we_o     (host_we),
        .host_be_o     (host_be),
        .host_wdata_o  (host_wdata),
        .host_rvalid_i (host_rvalid),
        .host_rdata_i  (host_rdata),
        .host_err_i    (host_err),
        .dma_irq_o     (dma_irq)
    );

    // Host memory model: reads return a pattern of the address, writes land in wmem.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    logic [31:0] wmem [0:1023];
    logic        random_mode = 1'b0;
    int          err_target = 0;

    logic        outst_q;
    logic [31:0] o_addr;
    logic        o_we;
    int          rsp_cnt;
    int          gnt_cnt;
    int          gnt_delay;
    int          rd_rsp_seen;
    logic        pend_q;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;
    int          hold_viol = 0;
    int          outst_viol = 0;
    logic [32:0] log_q [$];

    assign host_gnt    = host_req && !outst_q && (gnt_cnt >= gnt_delay);
    assign host_rvalid = outst_q && (rsp_cnt == 1);
    assign host_rdata  = (host_rvalid && !o_we) ? pat(o_addr) : 32'h0;
    assign host_err    = host_rvalid && !o_we && (rd_rsp_seen + 1 == err_target);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_q   <= 1'b0;
            o_addr    <= '0;
            o_we      <= 1'b0;
            rsp_cnt   <= 0;
            gnt_cnt   <= 0;
            gnt_delay <= 0;
            pend_q    <= 1'b0;
        end else begin
            if (pend_q && (host_req !== 1'b1 || host_addr !== hold_addr ||
                           host_we !== hold_we || host_wdata !== hold_wdata))
                hold_viol <= hold_viol + 1;
            if (host_req && outst_q) outst_viol <= outst_viol + 1;
            pend_q     <= host_req && !host_gnt;
            hold_addr  <= host_addr;
            hold_we    <= host_we;
            hold_wdata <= host_wdata;
            if (host_req && host_gnt) begin
                outst_q   <= 1'b1;
                o_addr    <= host_addr;
                o_we      <= host_we;
                rsp_cnt   <= random_mode ? int'($urandom_range(3, 1)) : 1;
                gnt_cnt   <= 0;
                gnt_delay <= random_mode ? int'($urandom_range(5, 0)) : 0;
                log_q.push_back({host_we, host_addr});
                if (host_we) wmem[host_addr[11:2]] <= host_wdata;
            end else begin
                if (host_req) gnt_cnt <= gnt_cnt + 1;
                if (outst_q) begin
                    if (rsp_cnt == 1) begin
                        outst_q <= 1'b0;
                        if (!o_we) rd_rsp_seen <= rd_rsp_seen + 1;
                    end else begin
                        rsp_cnt <= rsp_cnt - 1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Each access is issued in the current cycle; returns at the response cycle's negedge.
    task automatic dev_read(input logic [31:0] a, output logic [31:0] d, output logic e,
                            output logic v);
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = a; dev_wdata = '0; dev_be = 4'hF;
        @(negedge clk);
        dev_req = 1'b0;
        d = dev_rdata; e = dev_err; v = dev_rvalid;
    endtask

    task automatic dev_write(input logic [31:0] a, input logic [31:0] wd, output logic e);
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = a; dev_wdata = wd; dev_be = 4'h3;
        @(negedge clk);
        dev_req = 1'b0; dev_we = 1'b0;
        e = dev_err;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        logic e;
        dev_write(a, wd, e);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic e, v;
        dev_read(a, d, e, v);
        check(tag, d, exp);
    endtask

    task automatic wait_done(input string tag, input int bound);
        logic [31:0] d;
        logic e, v;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            dev_read(32'h10, d, e, v);
            if (d[1]) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic e, v;
        int base;
        bit found;

        repeat (3) @(negedge clk);
        check("rst_host_req", {31'b0, host_req}, 32'd0);
        check("rst_irq", {31'b0, dma_irq}, 32'd0);
        check("rst_dev_rvalid", {31'b0, dev_rvalid}, 32'd0);
        rst = 1'b0;
        rd_chk("rst_status", 32'h10, 32'h0);

        // Zero-wait copy of 4 words, cycle-exact completion.
        wr(32'h00, 32'h0010_0000);
        wr(32'h04, 32'h0010_0400);
        wr(32'h08, 32'd4);
        base = log_q.size();
        wr(32'h0C, 32'h1);
        check("t1_req_rise", {31'b0, host_req}, 32'd1);
        repeat (15) @(negedge clk);
        rd_chk("t1_status_c15", 32'h10, 32'h1);
        rd_chk("t1_status_c16", 32'h10, 32'h2);
        check("t1_txn_count", log_q.size() - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            logic [32:0] ent;
            logic [31:0] ea;
            ea = (i % 2 == 1) ? 32'h0010_0400 + 32'(4 * (i / 2)) : 32'h0010_0000 + 32'(4 * (i / 2));
            ent = (base + i < log_q.size()) ? log_q[base + i] : 33'h0;
            check($sformatf("t1_txn%0d", i), {ent[32], ent[30:0]},
                  {(i % 2 == 1) ? 1'b1 : 1'b0, ea[30:0]});
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("t1_copy%0d", k), wmem[10'h100 + k], pat(32'h0010_0000 + 32'(4 * k)));

        // Zero-length start with interrupt enabled.
        wr(32'h10, 32'h6);
        wr(32'h0C, 32'h2);
        check("t2_irq_idle", {31'b0, dma_irq}, 32'd0);
        wr(32'h08, 32'd0);
        base = log_q.size();
        wr(32'h0C, 32'h3);
        check("t2_irq_set", {31'b0, dma_irq}, 32'd1);
        check("t2_no_req", {31'b0, host_req}, 32'd0);
        rd_chk("t2_status", 32'h10, 32'h2);
        wr(32'h10, 32'h2);
        check("t2_irq_clr", {31'b0, dma_irq}, 32'd0);
        check("t2_no_txn", log_q.size() - base, 32'd0);

        // Random latency copy of 8 words.
        wr(32'h0C, 32'h0);
        random_mode = 1'b1;
        wr(32'h00, 32'h0010_0100);
        wr(32'h04, 32'h0010_0600);
        wr(32'h08, 32'd8);
        wr(32'h0C, 32'h1);
        wait_done("t3_done", 500);
        random_mode = 1'b0;
        for (int k = 0; k < 8; k++)
            check($sformatf("t3_copy%0d", k), wmem[10'h180 + k], pat(32'h0010_0100 + 32'(4 * k)));
        check("t3_hold_viol", hold_viol, 32'd0);
        check("t3_outst_viol", outst_viol, 32'd0);

        // Error on the third read response aborts the transfer.
        wr(32'h10, 32'h6);
        wr(32'h00, 32'h0010_0000);
        wr(32'h04, 32'h0010_0800);
        wr(32'h08, 32'd5);
        err_target = rd_rsp_seen + 3;
        base = log_q.size();
        wr(32'h0C, 32'h1);
        wait_done("t4_done", 200);
        repeat (10) @(negedge clk);
        err_target = 0;
        check("t4_txn_count", log_q.size() - base, 32'd5);
        rd_chk("t4_status", 32'h10, 32'h6);
        rd_chk("t4_src", 32'h00, 32'h0010_0000);
        rd_chk("t4_dst", 32'h04, 32'h0010_0800);
        rd_chk("t4_len", 32'h08, 32'd5);

        // Config writes while busy are ignored; reset mid-write abandons the transfer.
        wr(32'h10, 32'h6);
        wr(32'h00, 32'h0010_0000);
        wr(32'h04, 32'h0010_0C00);
        wr(32'h08, 32'd8);
        wr(32'h0C, 32'h1);
        wr(32'h00, 32'hDEAD_0000);
        wr(32'h08, 32'd3);
        wr(32'h0C, 32'h1);
        rd_chk("t5_src_locked", 32'h00, 32'h0010_0000);
        rd_chk("t5_len_locked", 32'h08, 32'd8);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (host_req && host_we) found = 1'b1;
            else @(negedge clk);
        end
        check("t5_wr_req_seen", {31'b0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_req", {31'b0, host_req}, 32'd0);
        check("t5_rst_addr", host_addr, 32'h0);
        check("t5_rst_wdata", host_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("t5_src_zero", 32'h00, 32'h0);
        rd_chk("t5_dst_zero", 32'h04, 32'h0);
        rd_chk("t5_len_zero", 32'h08, 32'h0);
        rd_chk("t5_ctrl_zero", 32'h0C, 32'h0);
        rd_chk("t5_status_zero", 32'h10, 32'h0);
        repeat (5) @(negedge clk);
        check("t5_idle_req", {31'b0, host_req}, 32'd0);

        // Unmapped offset.
        wr(32'h00, 32'h0000_0055);
        dev_read(32'h14, d, e, v);
        check("t6_rd_err", {31'b0, e}, 32'd1);
        check("t6_rd_rvalid", {31'b0, v}, 32'd1);
        check("t6_rd_data", d, 32'h0);
        @(negedge clk);
        check("t6_rvalid_drop", {31'b0, dev_rvalid}, 32'd0);
        dev_write(32'h14, 32'hFFFF_FFFF, e);
        check("t6_wr_err", {31'b0, e}, 32'd1);
        rd_chk("t6_src_kept", 32'h00, 32'h0000_0055);
        rd_chk("t6_status_kept", 32'h10, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
